// File: rtl/gin_pkg.sv
// Shared types and sizing for the GIN X-bus feeder: FSM states, FIFO entry layout
// and ID-counter width.
package gin_pkg;

    localparam int GIN_ID_SIZE    = 4;
    localparam int GIN_DATA_BITS  = 8;
    localparam int GIN_NUMS_SLAVE = 4;
    localparam int GIN_FIFO_DEPTH = 4;

    // A single-slave chain still needs a one-bit counter.
    function automatic int idcnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GIN_IDCNT_W = $clog2(GIN_NUMS_SLAVE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2,
        FINISH = 2'd3
    } gin_feeder_state_e;

    typedef struct packed {
        logic [GIN_ID_SIZE-1:0]   tag;
        logic [GIN_DATA_BITS-1:0] data;
    } gin_entry_t;

endpackage

// File: rtl/gin_sync_fifo.sv
// Small synchronous FIFO.
// The head entry is read straight from storage, and pointers carry an extra wrap bit
// so that full and empty can be told apart.
module gin_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage is cleared on reset so the bus sees zeros rather than stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/gin_feeder.sv
// GIN X-bus master-side feeder.
// It buffers tagged GLB data toward the bus and serialises ID loads into the
// multicast-controller scan chain.
module gin_feeder
    import gin_pkg::*;
#(
    parameter int ID_SIZE    = GIN_ID_SIZE,
    parameter int DATA_BITS  = GIN_DATA_BITS,
    parameter int NUMS_SLAVE = GIN_NUMS_SLAVE,
    parameter int FIFO_DEPTH = GIN_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_id_valid,
    input  logic [ID_SIZE-1:0]   cfg_id,
    output logic                 cfg_id_ready,
    output logic                 cfg_done,
    output logic                 busy,
    input  logic                 in_valid,
    input  logic [ID_SIZE-1:0]   in_tag,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 bus_valid,
    output logic [ID_SIZE-1:0]   bus_tag,
    output logic [DATA_BITS-1:0] bus_data,
    input  logic                 bus_ready,
    output logic                 set_id,
    output logic [ID_SIZE-1:0]   id_scan
);

    localparam int CNT_W = idcnt_w(NUMS_SLAVE);
    localparam int EW    = ID_SIZE + DATA_BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUMS_SLAVE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    gin_feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 set_id_q, set_id_d;
    logic [ID_SIZE-1:0]   id_scan_q, id_scan_d;
    logic                 rdy_en_q;

    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 accept_s;
    logic [EW-1:0]        head_s;

    // rdy_en_q keeps in_ready low while reset is held.
    assign in_ready     = rdy_en_q && (state_q == IDLE) && !full_s;
    assign push_s       = in_valid && in_ready;
    assign bus_valid    = !empty_s;
    assign pop_s        = bus_valid && bus_ready;
    assign bus_tag      = head_s[EW-1 -: ID_SIZE];
    assign bus_data     = head_s[DATA_BITS-1:0];
    assign accept_s     = (state_q == LOAD) && cfg_id_valid;
    assign cfg_id_ready = (state_q == LOAD);
    assign cfg_done     = (state_q == FINISH);
    assign busy         = (state_q != IDLE);
    assign set_id       = set_id_q;
    assign id_scan      = id_scan_q;

    gin_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i ({in_tag, in_data}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Next-state and scan-chain control for the ID load sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_id_d  = 1'b0;
        id_scan_d = id_scan_q;
        case (state_q)
            IDLE: begin
                // A push in the same cycle as cfg_start leaves one entry behind, so drain it first.
                if (cfg_start) begin
                    if (empty_s && !push_s) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (empty_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = DRAIN;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    set_id_d  = 1'b1;
                    id_scan_d = cfg_id;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FINISH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and scan-output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            set_id_q  <= 1'b0;
            id_scan_q <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            set_id_q  <= set_id_d;
            id_scan_q <= id_scan_d;
            rdy_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gin_feeder.sv
// Directed bench for gin_feeder.
// It compares every cycle against a queue-based model and checks hand-computed
// values at key points.
module tb_gin_feeder;

    localparam int IDW = 4;
    localparam int DW  = 8;
    localparam int NS  = 4;
    localparam int FD  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cfg_start = 1'b0;
    logic           cfg_id_valid = 1'b0;
    logic [IDW-1:0] cfg_id = '0;
    logic           cfg_id_ready;
    logic           cfg_done;
    logic           busy;
    logic           in_valid = 1'b0;
    logic [IDW-1:0] in_tag = '0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           bus_valid;
    logic [IDW-1:0] bus_tag;
    logic [DW-1:0]  bus_data;
    logic           bus_ready = 1'b0;
    logic           set_id;
    logic [IDW-1:0] id_scan;

    always #5 clk = ~clk;

    gin_feeder #(.ID_SIZE(IDW), .DATA_BITS(DW), .NUMS_SLAVE(NS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_id_valid(cfg_id_valid),
        .cfg_id(cfg_id), .cfg_id_ready(cfg_id_ready), .cfg_done(cfg_done), .busy(busy),
        .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data), .in_ready(in_ready),
        .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_data(bus_data), .bus_ready(bus_ready),
        .set_id(set_id), .id_scan(id_scan)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { int tag; int data; } ent_t;
    ent_t q[$];
    int   m_st;       // 0 idle, 1 drain, 2 load, 3 finish
    int   m_cnt;
    int   m_set;
    int   m_scan;
    int   m_rdy_en;
    int   chain[NS];
    int   pulses;
    int   ids_a[4] = '{7, 6, 5, 4};
    int   ids_b[4] = '{9, 10, 11, 12};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_in_ready();
        return (m_rdy_en != 0 && m_st == 0 && q.size() < FD) ? 1 : 0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_st = 0; m_cnt = 0; m_set = 0; m_scan = 0; m_rdy_en = 0;
    endtask

    task automatic model_step();
        int   push, pop, acc, nst;
        ent_t e;
        push = (in_valid && m_in_ready() != 0) ? 1 : 0;
        pop  = (q.size() != 0 && bus_ready) ? 1 : 0;
        acc  = (m_st == 2 && cfg_id_valid) ? 1 : 0;
        nst  = m_st;
        if (m_st == 0 && cfg_start) nst = (q.size() == 0 && push == 0) ? 2 : 1;
        if (m_st == 1 && q.size() == 0) nst = 2;
        if (m_st == 3) nst = 0;
        m_set = acc;
        if (acc != 0) begin
            m_scan = int'(cfg_id);
            if (m_cnt == NS - 1) begin
                nst = 3;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (pop != 0) void'(q.pop_front());
        if (push != 0) begin
            e.tag = int'(in_tag);
            e.data = int'(in_data);
            q.push_back(e);
        end
        m_st = nst;
        m_rdy_en = 1;
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, m_in_ready());
        chk("bus_valid", bus_valid, (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) begin
            chk("bus_tag", bus_tag, q[0].tag);
            chk("bus_data", bus_data, q[0].data);
        end
        chk("cfg_id_ready", cfg_id_ready, (m_st == 2) ? 1 : 0);
        chk("cfg_done", cfg_done, (m_st == 3) ? 1 : 0);
        chk("busy", busy, (m_st != 0) ? 1 : 0);
        chk("set_id", set_id, m_set);
        chk("id_scan", id_scan, m_scan);
        if (set_id === 1'b1) begin
            for (int k = NS - 1; k > 0; k--) chain[k] = chain[k-1];
            chain[0] = int'(id_scan);
            pulses++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, "_in_ready"}, in_ready, 0);
        chk({tagname, "_bus_valid"}, bus_valid, 0);
        chk({tagname, "_bus_tag"}, bus_tag, 0);
        chk({tagname, "_bus_data"}, bus_data, 0);
        chk({tagname, "_cfg_id_ready"}, cfg_id_ready, 0);
        chk({tagname, "_cfg_done"}, cfg_done, 0);
        chk({tagname, "_busy"}, busy, 0);
        chk({tagname, "_set_id"}, set_id, 0);
        chk({tagname, "_id_scan"}, id_scan, 0);
    endtask

    initial begin
        model_reset();
        pulses = 0;
        for (int k = 0; k < NS; k++) chain[k] = 0;

        // Reset and release
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_bus_valid", bus_valid, 0);

        // Single push with bus_ready=1
        bus_ready = 1'b1;
        in_valid = 1'b1; in_tag = 4'd3; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("one_valid", bus_valid, 1);
        chk("one_tag", bus_tag, 3);
        chk("one_data", bus_data, 8'hA5);
        tick();
        chk("one_empty", bus_valid, 0);

        // Fill past depth while stalled, then drain in order
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_tag = IDW'(i + 1); in_data = DW'(8'h10 + i);
            tick();
            if (i == 3) chk("full_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stall_tag", bus_tag, 1);
        chk("stall_data", bus_data, 8'h10);
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", bus_tag, i + 1);
            chk("drain_data", bus_data, 8'h10 + i);
            tick();
        end
        chk("drain_empty", bus_valid, 0);

        // ID load with one-cycle gaps
        pulses = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("load_ready", cfg_id_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cfg_id_valid = 1'b1; cfg_id = IDW'(ids_a[i]);
            tick();
            cfg_id_valid = 1'b0;
            chk("gap_set_id", set_id, 1);
            chk("gap_id_scan", id_scan, ids_a[i]);
            chk("gap_in_ready", in_ready, 0);
            chk("gap_cfg_done", cfg_done, (i == 3) ? 1 : 0);
            tick();
            chk("gap_idle_set", set_id, 0);
        end
        chk("load_pulses", pulses, 4);
        chk("slave0", chain[0], 4);
        chk("slave1", chain[1], 5);
        chk("slave2", chain[2], 6);
        chk("slave3", chain[3], 7);
        chk("post_load_in_ready", in_ready, 1);

        // Drain before load
        bus_ready = 1'b0;
        in_valid = 1'b1; in_tag = 4'd8; in_data = 8'h80;
        tick();
        in_tag = 4'd9; in_data = 8'h81;
        tick();
        in_valid = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_no_idready", cfg_id_ready, 0);
        chk("drain_in_ready", in_ready, 0);
        bus_ready = 1'b1;
        tick();
        tick();
        chk("drain_now_empty", bus_valid, 0);
        chk("drain_still", cfg_id_ready, 0);
        tick();
        chk("drain_to_load", cfg_id_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cfg_id_valid = 1'b1; cfg_id = IDW'(i + 1);
            tick();
        end
        cfg_id_valid = 1'b0;
        chk("b2b_done", cfg_done, 1);
        tick();

        // Reset in the middle of a load, then reload
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_id_valid = 1'b1; cfg_id = 4'd3;
        tick();
        cfg_id = 4'd5;
        tick();
        cfg_id_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_set_id", set_id, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", cfg_done, 0);
        chk("abort_idready", cfg_id_ready, 0);
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_id_valid = 1'b1; cfg_id = IDW'(ids_b[i]);
            tick();
            if (i < 3) chk("reload_not_done", cfg_done, 0);
        end
        cfg_id_valid = 1'b0;
        chk("reload_done", cfg_done, 1);
        chk("reload_scan", id_scan, 12);
        tick();
        chk("reload_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gin_feeder.md
Name: gin_feeder

Overview:
- Upstream stage of the GIN X-bus (`GIN_Bus` master side).
- Accepts tagged data from the GLB side, buffers it in a small FIFO, and drives the bus master handshake (tag/valid/data/ready).
- Also owns ID configuration of the bus's multicast-controller scan chain: it serialises a stream of NUMS_SLAVE IDs onto set_id / ID_scan_in, with data traffic blocked while that happens.

Parameters:
ID_SIZE, `XID_BITS, width of tags and IDs
NUMS_SLAVE, `NUMS_PE_COL, number of controllers in the downstream ID chain
FIFO_DEPTH, 4, data FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
cfg_start  input  1  single-cycle request to begin an ID load
cfg_id_valid  input  1  ID stream valid
cfg_id  input  ID_SIZE  ID value; last slave's ID first
cfg_id_ready  output  1  ID accepted when valid&ready
cfg_done  output  1  one-cycle pulse when the chain is fully loaded
busy  output  1  FSM not in IDLE
in_valid  input  1  GLB data valid
in_tag  input  ID_SIZE  destination tag
in_data  input  `DATA_BITS  payload
in_ready  output  1  GLB handshake ready
bus_valid  output  1  to bus master_valid
bus_tag  output  ID_SIZE  to bus tag
bus_data  output  `DATA_BITS  to bus master_data
bus_ready  input  1  from bus master_ready
set_id  output  1  to bus set_id
id_scan  output  ID_SIZE  to bus ID_scan_in

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; FIFO empty; ID counter 0.
  - All outputs 0, except in_ready, which becomes 1 on the first cycle after reset release.
- FSM states:
  - IDLE: data path open. cfg_start -> LOAD if FIFO empty, else -> DRAIN.
  - DRAIN: in_ready=0; FIFO keeps emitting. Go to LOAD in the cycle after the FIFO becomes empty.
  - LOAD: cfg_id_ready=1, in_ready=0. Each accepted ID registers set_id=1 and id_scan=cfg_id for exactly the next cycle. Otherwise set_id=0 and id_scan holds its last value. Accept count runs 0..NUMS_SLAVE-1. Accepting at count NUMS_SLAVE-1 -> FINISH, counter cleared.
  - FINISH: lasts one cycle. The registered set_id=1 for the final ID is visible here, cfg_done=1. Then -> IDLE.
  - cfg_start outside IDLE is ignored. cfg_id_valid outside LOAD is not acknowledged.
- Chain order: NUMS_SLAVE set_id pulses shift the IDs in, so the first ID sent ends in slave NUMS_SLAVE-1 and the last ID sent ends in slave 0. cfg_id_valid gaps are allowed; the shift occurs only on accepted IDs.
- Data FIFO:
  - in_ready = (state==IDLE) && !full.
  - Push on in_valid&&in_ready; entry stores {tag,data}.
  - bus_valid = !empty. bus_tag and bus_data come from the head entry, directly from storage.
  - Pop on bus_valid&&bus_ready.
  - Latency: data accepted in cycle N is presented on bus_valid in cycle N+1 at the earliest. No combinational in->bus path.
  - Simultaneous push and pop when not empty and not full: occupancy unchanged.
  - When full, in_ready=0, so no push is possible even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra wrap bit.
  - While bus_valid=1 and bus_ready=0, head tag/data must stay stable.
- Reset during LOAD: the load is aborted and no cfg_done is produced. The downstream chain is partial and must be reloaded by a new cfg_start.
- bus_valid never rises while set_id=1. The FIFO is empty from LOAD entry through FINISH, and pushes are blocked until IDLE.

Decomposition:
- gin_pkg holds:
  - gin_feeder_state_e {IDLE, DRAIN, LOAD, FINISH}
  - gin_entry_t struct {tag, data}
  - an ID-counter width localparam computed as $clog2(NUMS_SLAVE).
- One sub-module, gin_sync_fifo, parameterised on width/depth, with push/pop/full/empty.
- The FSM, ID counter and set_id/id_scan registers stay in gin_feeder.

Test Plan:
- Reset release, NUMS_SLAVE=4: all outputs 0 during reset. in_ready=1 and bus_valid=0 on the first cycle after release.
- Push tag=3, data=0xA5 with bus_ready=1: bus_valid=1, tag=3, data=0xA5 one cycle later; popped that cycle; FIFO empty after.
- bus_ready=0, push 5 entries with FIFO_DEPTH=4: in_ready drops after the 4th push. Raising bus_ready drains all 4 in order, with data held stable while stalled.
- FIFO empty, cfg_start, IDs 7,6,5,4 with one-cycle valid gaps:
  - set_id pulses 4 times, with id_scan 7,6,5,4 each one cycle after its accept.
  - cfg_done occurs in the cycle of the 4th set_id.
  - in_ready=0 throughout; bus tag routing afterwards hits slave0=4 and slave3=7.
- 2 entries queued with bus_ready=0, then cfg_start: state DRAIN, cfg_id_ready=0. After bus_ready=1 pops both, LOAD begins the next cycle.
- rst asserted after 2 of 4 IDs accepted: immediate IDLE, set_id=0, no cfg_done. A new load of 4 IDs then completes normally.
